// File: rtl/tl_sram_responder.sv
// TL-UH device-side responder that answers uncached Get/Put traffic from a
// single-port synchronous SRAM. One transaction is in flight at a time;
// unsupported opcodes and out-of-range addresses get denied responses.
module tl_sram_responder #(
  parameter int DataWidth    = 64,
  parameter int AddrWidth    = 56,
  parameter int SourceWidth  = 1,
  parameter int SinkWidth    = 1,
  parameter int MaxSize      = 6,
  parameter int RamAddrWidth = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  output logic                      host_a_ready,
  input  logic                      host_a_valid,
  input  logic [2:0]                host_a_opcode,
  input  logic [2:0]                host_a_param,
  input  logic [2:0]                host_a_size,
  input  logic [SourceWidth-1:0]    host_a_source,
  input  logic [AddrWidth-1:0]      host_a_address,
  input  logic [DataWidth/8-1:0]    host_a_mask,
  input  logic                      host_a_corrupt,
  input  logic [DataWidth-1:0]      host_a_data,

  input  logic                      host_d_ready,
  output logic                      host_d_valid,
  output logic [2:0]                host_d_opcode,
  output logic [1:0]                host_d_param,
  output logic [2:0]                host_d_size,
  output logic [SourceWidth-1:0]    host_d_source,
  output logic [SinkWidth-1:0]      host_d_sink,
  output logic                      host_d_denied,
  output logic                      host_d_corrupt,
  output logic [DataWidth-1:0]      host_d_data,

  output logic                      ram_req_o,
  output logic                      ram_we_o,
  output logic [RamAddrWidth-1:0]   ram_addr_o,
  output logic [DataWidth/8-1:0]    ram_wmask_o,
  output logic [DataWidth-1:0]      ram_wdata_o,
  input  logic [DataWidth-1:0]      ram_rdata_i
);

  localparam int Bytes   = DataWidth / 8;
  localparam int OffBits = $clog2(Bytes);
  // Wide enough for 2^(7-OffBits) beats, the largest a 3-bit size can encode.
  localparam int BeatW   = 8;

  localparam logic [2:0] OffSize = 3'(OffBits);
  localparam logic [2:0] MaxSz   = 3'(MaxSize);

  // A-channel opcodes
  localparam logic [2:0] OpPutFull = 3'd0;
  localparam logic [2:0] OpPutPart = 3'd1;
  localparam logic [2:0] OpArith   = 3'd2;
  localparam logic [2:0] OpLogic   = 3'd3;
  localparam logic [2:0] OpGet     = 3'd4;
  localparam logic [2:0] OpIntent  = 3'd5;

  // D-channel opcodes
  localparam logic [2:0] DAccessAck     = 3'd0;
  localparam logic [2:0] DAccessAckData = 3'd1;
  localparam logic [2:0] DHintAck       = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_ACK,
    ST_DENY
  } state_t;

  state_t                    state, state_next;
  logic [2:0]                cur_op, op_next;
  logic [2:0]                cur_size, size_next;
  logic [SourceWidth-1:0]    cur_source, source_next;
  logic [RamAddrWidth-1:0]   cur_word, word_next;
  logic [BeatW-1:0]          beats_left, beats_next;
  logic                      out_of_range, oor_next;

  logic [RamAddrWidth-1:0]   a_word;
  logic                      a_in_range;
  logic [BeatW-1:0]          a_beats;
  logic                      a_fire;
  logic                      d_fire;

  // Fields the responder deliberately does not interpret.
  logic unused_inputs;
  assign unused_inputs = ^{host_a_param, host_a_corrupt, host_a_address[OffBits-1:0]};

  // Number of data beats a transfer of the given log2 size occupies.
  function automatic logic [BeatW-1:0] beats_of(input logic [2:0] size);
    if (size <= OffSize) return BeatW'(1);
    return BeatW'(1) << (size - OffSize);
  endfunction

  function automatic logic is_put(input logic [2:0] op);
    return (op == OpPutFull) || (op == OpPutPart);
  endfunction

  // Requests whose denial still carries a data-shaped (corrupt) response.
  function automatic logic deny_with_data(input logic [2:0] op);
    return (op == OpGet) || (op == OpArith) || (op == OpLogic);
  endfunction

  assign a_word     = host_a_address[OffBits +: RamAddrWidth];
  assign a_in_range = ~|host_a_address[AddrWidth-1:OffBits+RamAddrWidth];
  assign a_beats    = beats_of(host_a_size);
  // Handshakes never complete while reset is held.
  assign a_fire     = rst_ni & host_a_valid;
  assign d_fire     = rst_ni & host_d_ready;

  assign host_d_param  = 2'b00;
  assign host_d_sink   = '0;
  assign host_d_size   = cur_size;
  assign host_d_source = cur_source;
  assign ram_wdata_o   = host_a_data;

  // Next-state, latched-request and channel/SRAM output decode.
  always_comb begin
    state_next     = state;
    op_next        = cur_op;
    size_next      = cur_size;
    source_next    = cur_source;
    word_next      = cur_word;
    beats_next     = beats_left;
    oor_next       = out_of_range;

    host_a_ready   = 1'b0;
    host_d_valid   = 1'b0;
    host_d_opcode  = DAccessAck;
    host_d_denied  = 1'b0;
    host_d_corrupt = 1'b0;
    host_d_data    = '0;

    ram_req_o      = 1'b0;
    ram_we_o       = 1'b0;
    ram_addr_o     = cur_word;
    ram_wmask_o    = '0;

    case (state)
      ST_IDLE: begin
        host_a_ready = rst_ni;
        if (a_fire) begin
          op_next     = host_a_opcode;
          size_next   = host_a_size;
          source_next = host_a_source;
          oor_next    = ~a_in_range;
          word_next   = a_word;
          case (host_a_opcode)
            OpGet: begin
              beats_next = a_beats;
              if (a_in_range) begin
                ram_req_o  = 1'b1;
                ram_addr_o = a_word;
                state_next = ST_READ;
              end else begin
                state_next = ST_DENY;
              end
            end
            OpPutFull, OpPutPart: begin
              if (a_in_range) begin
                ram_req_o   = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = a_word;
                ram_wmask_o = host_a_mask;
              end
              word_next  = a_word + RamAddrWidth'(1);
              beats_next = a_beats - BeatW'(1);
              state_next = (a_beats == BeatW'(1)) ? ST_ACK : ST_WRITE;
            end
            OpArith, OpLogic: begin
              // Drain the remaining put beats before answering with a denial.
              if (a_beats == BeatW'(1)) begin
                beats_next = a_beats;
                state_next = ST_DENY;
              end else begin
                beats_next = a_beats - BeatW'(1);
                state_next = ST_WRITE;
              end
            end
            default: begin
              beats_next = BeatW'(1);
              state_next = ST_DENY;
            end
          endcase
        end
      end

      ST_READ: begin
        host_d_valid  = 1'b1;
        host_d_opcode = DAccessAckData;
        host_d_data   = ram_rdata_i;
        if (d_fire) begin
          if (beats_left == BeatW'(1)) begin
            state_next = ST_IDLE;
          end else begin
            // Fetch the next word now so it is ready on the following cycle.
            ram_req_o  = 1'b1;
            ram_addr_o = cur_word + RamAddrWidth'(1);
            word_next  = cur_word + RamAddrWidth'(1);
            beats_next = beats_left - BeatW'(1);
          end
        end
      end

      ST_WRITE: begin
        host_a_ready = rst_ni;
        if (a_fire) begin
          if (!out_of_range && is_put(cur_op)) begin
            ram_req_o   = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = cur_word;
            ram_wmask_o = host_a_mask;
          end
          word_next  = cur_word + RamAddrWidth'(1);
          beats_next = beats_left - BeatW'(1);
          if (beats_left == BeatW'(1)) begin
            if (is_put(cur_op)) begin
              state_next = ST_ACK;
            end else begin
              beats_next = beats_of(cur_size);
              state_next = ST_DENY;
            end
          end
        end
      end

      ST_ACK: begin
        host_d_valid  = 1'b1;
        host_d_opcode = DAccessAck;
        host_d_denied = out_of_range;
        if (d_fire) state_next = ST_IDLE;
      end

      ST_DENY: begin
        host_d_valid  = 1'b1;
        host_d_denied = 1'b1;
        if (deny_with_data(cur_op)) begin
          host_d_opcode  = DAccessAckData;
          host_d_corrupt = 1'b1;
        end else if (cur_op == OpIntent) begin
          host_d_opcode = DHintAck;
        end
        if (d_fire) begin
          if (beats_left == BeatW'(1)) state_next = ST_IDLE;
          else                         beats_next = beats_left - BeatW'(1);
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset discards any in-flight transaction.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Latched request fields; only meaningful while state is not Idle.
  always_ff @(posedge clk_i) begin
    cur_op       <= op_next;
    cur_size     <= size_next;
    cur_source   <= source_next;
    cur_word     <= word_next;
    beats_left   <= beats_next;
    out_of_range <= oor_next;
  end

  // Transfers larger than MaxSize are a host protocol violation.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (host_a_valid && host_a_ready && state == ST_IDLE) |-> (host_a_size <= MaxSz));

endmodule
